// File: rtl/lane_sensor_conditioner_if.sv
// Lane sensor bundle between the loop-detector front end and the traffic-light controller.
// The master side drives the raw detector levels and served pulses; the slave side returns the conditioned indications.
interface lane_sensor_conditioner_if;
  logic [3:0] raw_start;
  logic [3:0] raw_far;
  logic [3:0] served;
  logic [3:0] s1;
  logic [3:0] s5;
  logic [3:0] start_f;

  modport master (
    output raw_start, raw_far, served,
    input  s1, s5, start_f
  );

  modport slave (
    input  raw_start, raw_far, served,
    output s1, s5, start_f
  );
endinterface

// File: rtl/lane_sensor_conditioner.sv
// Per-lane loop-detector conditioning: sync, debounce, request latch (s1), congestion flag (s5).
// Define LSC_SYNC_EN to insert the 2-flop synchroniser ahead of the debouncers.
module lane_sensor_conditioner #(
  parameter int DEB_CYCLES  = 4,
  parameter int CONG_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  lane_sensor_conditioner_if.slave     bus
);

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CONG_MAX = CNT_W'(CONG_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CONG_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic [7:0] raw_all;
  logic [7:0] samp;

  // Channels 0..3 are the start loops, 4..7 the far loops.
  assign raw_all = {bus.raw_far, bus.raw_start};

  // ---- stage p0/p1: synchroniser ----
`ifdef LSC_SYNC_EN
  logic [7:0] sync_p0;
  logic [7:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_all;
      sync_p1 <= sync_p0;
    end
  end

  assign samp = sync_p1;
`else
  assign samp = raw_all;
`endif

  // ---- stage p2: debounce ----
  logic [7:0]       filt_p2;
  logic [CNT_W-1:0] deb_cnt_p2 [8];
  logic [CNT_W-1:0] deb_inc    [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      deb_inc[i] = deb_cnt_p2[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_p2    <= '0;
      deb_cnt_p2 <= '{default: '0};
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (samp[i] == filt_p2[i]) begin
          deb_cnt_p2[i] <= '0;
        end else if (deb_inc[i] == DEB_MAX) begin
          filt_p2[i]    <= ~filt_p2[i];
          deb_cnt_p2[i] <= '0;
        end else begin
          deb_cnt_p2[i] <= deb_inc[i];
        end
      end
    end
  end

  logic [3:0] start_f;
  logic [3:0] far_f;

  assign start_f = filt_p2[3:0];
  assign far_f   = filt_p2[7:4];

  // ---- stage p3: request latch and congestion window ----
  logic [3:0]       s1_p3;
  logic [3:0]       s5_p3;
  logic [CNT_W-1:0] cong_cnt_p3 [4];
  logic [CNT_W-1:0] cong_nxt    [4];

  // served restarts the window so an extension needs a full fresh occupancy period.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      cong_nxt[l] = (!far_f[l] || bus.served[l]) ? '0 : sat_inc(cong_cnt_p3[l]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p3       <= '0;
      s5_p3       <= '0;
      cong_cnt_p3 <= '{default: '0};
    end else begin
      s1_p3 <= start_f | (s1_p3 & ~bus.served);
      for (int l = 0; l < 4; l++) begin
        cong_cnt_p3[l] <= cong_nxt[l];
        s5_p3[l]       <= (cong_nxt[l] == CONG_MAX);
      end
    end
  end

  assign bus.s1      = s1_p3;
  assign bus.s5      = s5_p3;
  assign bus.start_f = start_f;

endmodule

// File: tb/tb_lane_sensor_conditioner.sv
// Directed bench for lane_sensor_conditioner: reset, glitch rejection, arrival latch,
// served handling, congestion window and parallel lanes.
module tb_lane_sensor_conditioner;

  localparam int D = 4;
  localparam int C = 16;
`ifdef LSC_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic exp_b;
  logic exp_b2;

  lane_sensor_conditioner_if bus ();

  lane_sensor_conditioner #(
    .DEB_CYCLES  (D),
    .CONG_CYCLES (C),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.raw_start = 4'b0;
    bus.raw_far   = 4'b0;
    bus.served    = 4'b0;

    // Reset state
    ticks(2);
    check_eq("rst_s1", bus.s1, 4'b0);
    check_eq("rst_s5", bus.s5, 4'b0);
    check_eq("rst_start_f", bus.start_f, 4'b0);
    rst_n = 1'b1;
    ticks(3);
    check_eq("post_rst_s1", bus.s1, 4'b0);
    check_eq("post_rst_start_f", bus.start_f, 4'b0);

    // Glitch rejection: 3-edge pulse never reaches the filtered level
    bus.raw_start[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) bus.raw_start[0] = 1'b0;
      check_eq($sformatf("glitch_start_f_e%0d", e), bus.start_f[0], 1'b0);
      check_eq($sformatf("glitch_s1_e%0d", e), bus.s1[0], 1'b0);
    end

    // Arrival on lane 1
    bus.raw_start[1] = 1'b1;
    for (int e = 1; e <= D + L + 2; e++) begin
      tick();
      exp_b  = (e >= D + L);
      exp_b2 = (e >= D + L + 1);
      check_eq($sformatf("arr_start_f_e%0d", e), bus.start_f[1], exp_b);
      check_eq($sformatf("arr_s1_e%0d", e), bus.s1[1], exp_b2);
    end
    bus.raw_start[1] = 1'b0;
    ticks(D + L + 2);
    check_eq("arr_left_start_f", bus.start_f[1], 1'b0);
    check_eq("arr_left_s1_held", bus.s1[1], 1'b1);
    bus.served[1] = 1'b1;
    tick();
    bus.served[1] = 1'b0;
    check_eq("arr_served_s1", bus.s1, 4'b0000);

    // Served while the car is still on the loop
    bus.raw_start[2] = 1'b1;
    ticks(D + L + 2);
    check_eq("car_present_s1", bus.s1, 4'b0100);
    bus.served[2] = 1'b1;
    tick();
    bus.served[2] = 1'b0;
    check_eq("served_busy_s1", bus.s1[2], 1'b1);
    bus.raw_start[2] = 1'b0;
    ticks(D + L + 1);
    bus.served[2] = 1'b1;
    tick();
    bus.served[2] = 1'b0;
    check_eq("served_empty_s1", bus.s1, 4'b0000);

    // Congestion window on lane 3, served at edge 30 restarts it
    bus.raw_far[3] = 1'b1;
    for (int e = 1; e <= 48; e++) begin
      if (e == 30) bus.served[3] = 1'b1;
      tick();
      bus.served[3] = 1'b0;
      exp_b = (e < 30) ? (e >= L + D + C) : (e >= 30 + C);
      check_eq($sformatf("cong_s5_e%0d", e), bus.s5, {exp_b, 3'b000});
    end
    bus.raw_far[3] = 1'b0;
    ticks(D + L);
    check_eq("cong_far_fall_s5_held", bus.s5[3], 1'b1);
    tick();
    check_eq("cong_far_fall_s5_drop", bus.s5[3], 1'b0);
    check_eq("cong_no_s1", bus.s1, 4'b0000);

    // Parallel lanes
    bus.raw_start = 4'b1111;
    ticks(D + L);
    check_eq("par_start_f", bus.start_f, 4'b1111);
    check_eq("par_s1_before", bus.s1, 4'b0000);
    tick();
    check_eq("par_s1_set", bus.s1, 4'b1111);
    bus.raw_start = 4'b0000;
    ticks(D + L + 2);
    check_eq("par_loops_empty", bus.start_f, 4'b0000);
    bus.served = 4'b0101;
    tick();
    bus.served = 4'b0000;
    check_eq("par_served_s1", bus.s1, 4'b1010);

    // Reset mid-operation with requests and congestion pending
    bus.raw_start = 4'b1111;
    bus.raw_far   = 4'b1111;
    ticks(D + L + C + 1);
    check_eq("pre_rst_s1", bus.s1, 4'b1111);
    check_eq("pre_rst_s5", bus.s5, 4'b1111);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_s1", bus.s1, 4'b0000);
    check_eq("mid_rst_s5", bus.s5, 4'b0000);
    check_eq("mid_rst_start_f", bus.start_f, 4'b0000);
    bus.raw_start = 4'b0000;
    bus.raw_far   = 4'b0000;
    ticks(2);
    rst_n = 1'b1;
    ticks(D + L + C + 2);
    check_eq("after_rst_s1", bus.s1, 4'b0000);
    check_eq("after_rst_s5", bus.s5, 4'b0000);
    check_eq("after_rst_start_f", bus.start_f, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
